// File: rtl/core_bus_arbiter_pkg.sv
// Shared types and helpers for the core bus arbiter.
//   arb_state_t : arbiter sequencing states (idle, request phase, response phase)
//   arb_owner_t : which requester owns the transfer in flight
//   IBUS_SIZE   : fixed downstream size code for instruction fetches (4 bytes)
//   ibus_word() : picks the 32-bit instruction word out of a 64-bit beat
package core_bus_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  localparam logic [2:0] IBUS_SIZE = 3'd2;

  function automatic logic [31:0] ibus_word(input logic hi_i, input logic [63:0] rdata_i);
    return hi_i ? rdata_i[63:32] : rdata_i[31:0];
  endfunction

endpackage

// File: rtl/core_bus_arbiter_if.sv
// Bundle of all handshake and bus signals around the core bus arbiter.
//   ibus : i_valid/i_addr in, i_data_ok/i_data out
//   dbus : d_valid/d_addr/d_size/d_strobe/d_wdata in, d_data_ok/d_rdata out
//   mem  : m_valid/m_write/m_addr/m_size/m_strobe/m_wdata out, m_ready/m_rvalid/m_rdata in
//   stat : busy, timeout out
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding pipeline + memory view
interface core_bus_arbiter_if;

  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_data_ok;
  logic [31:0] i_data;

  logic        d_valid;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_data_ok;
  logic [63:0] d_rdata;

  logic        m_valid;
  logic        m_write;
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  logic [63:0] m_wdata;
  logic        m_ready;
  logic        m_rvalid;
  logic [63:0] m_rdata;

  logic        busy;
  logic        timeout;

  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata,
    input  m_ready, m_rvalid, m_rdata,
    output i_data_ok, i_data, d_data_ok, d_rdata,
    output m_valid, m_write, m_addr, m_size, m_strobe, m_wdata,
    output busy, timeout
  );

  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata,
    output m_ready, m_rvalid, m_rdata,
    input  i_data_ok, i_data, d_data_ok, d_rdata,
    input  m_valid, m_write, m_addr, m_size, m_strobe, m_wdata,
    input  busy, timeout
  );

endinterface

// File: rtl/core_bus_arbiter_watchdog.sv
// Watchdog counter for one outstanding arbiter transfer.
//   clk      : clock
//   reset    : asynchronous active-low reset
//   load_i   : clear the count (a new transfer is being granted)
//   en_i     : count this cycle (a transfer is outstanding)
//   expire_o : transfer has been outstanding for TIMEOUT cycles (including this one)
module arb_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Holds at the last value instead of wrapping; the arbiter always leaves
  // the busy states on expiry, so the hold is only a safety net.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/core_bus_arbiter.sv
// Shares one downstream memory port between instruction fetch (ibus) and
// data access (dbus). Each transfer is a request phase (m_valid until
// m_ready) followed by a response phase (until m_rvalid). dbus normally wins,
// but ibus is forced first after IWAIT_MAX consecutive dbus grants while it
// waits. A watchdog aborts any transfer outstanding for TIMEOUT cycles.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : core_bus_arbiter_if.slave (ibus, dbus, memory and status signals)
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int IWAIT_MAX = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  core_bus_arbiter_if.slave         bus
);

  localparam int SC_W = $clog2(IWAIT_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(IWAIT_MAX);

  arb_state_t       state_q, state_d;
  arb_owner_t       owner_q, owner_d;
  logic [SC_W-1:0]  starve_q, starve_d;
  logic             timeout_q, timeout_d;

  logic             in_req, in_wait, busy;
  logic             grant, pick_i;
  logic             rsp_done, wd_expire, abort, finish, own_d;
  logic [63:0]      rsp_data;

  assign in_req  = (state_q == ARB_REQ);
  assign in_wait = (state_q == ARB_WAIT);
  assign busy    = in_req | in_wait;
  assign own_d   = (owner_q == OWN_D);

  assign grant  = (state_q == ARB_IDLE) & (bus.i_valid | bus.d_valid);
  // ibus takes the grant when alone, or when it has been passed over too often.
  assign pick_i = bus.i_valid & (~bus.d_valid | (starve_q >= STARVE_MAX));

  // A response may arrive together with acceptance while still in REQ.
  assign rsp_done = (in_req & bus.m_ready & bus.m_rvalid) | (in_wait & bus.m_rvalid);
  // A real response in the expiry cycle wins over the abort.
  assign abort    = wd_expire & ~rsp_done;
  assign finish   = rsp_done | abort;
  // Aborted transfers return zero data.
  assign rsp_data = rsp_done ? bus.m_rdata : 64'h0;

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .load_i   (grant),
    .en_i     (busy),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    timeout_d = timeout_q | abort;
    case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          state_d = ARB_REQ;
          owner_d = pick_i ? OWN_I : OWN_D;
          // Only a dbus grant that leaves ibus waiting counts toward starvation.
          if (!pick_i && bus.i_valid) begin
            if (starve_q != STARVE_MAX) starve_d = starve_q + SC_W'(1);
          end else begin
            starve_d = '0;
          end
        end
      end
      ARB_REQ: begin
        if (finish) begin
          state_d = ARB_IDLE;
        end else if (bus.m_ready) begin
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (finish) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_I;
      starve_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      timeout_q <= timeout_d;
    end
  end

  // Request fields are forced to zero outside REQ so nothing leaks while idle or in reset.
  assign bus.m_valid  = in_req;
  assign bus.m_write  = in_req & own_d & (|bus.d_strobe);
  assign bus.m_addr   = in_req ? (own_d ? bus.d_addr : bus.i_addr) : 64'h0;
  assign bus.m_size   = in_req ? (own_d ? bus.d_size : IBUS_SIZE) : 3'd0;
  assign bus.m_strobe = (in_req & own_d) ? bus.d_strobe : 8'h00;
  assign bus.m_wdata  = (in_req & own_d) ? bus.d_wdata : 64'h0;

  assign bus.i_data_ok = finish & ~own_d;
  assign bus.d_data_ok = finish & own_d;
  assign bus.i_data    = bus.i_data_ok ? ibus_word(bus.i_addr[2], rsp_data) : 32'h0;
  assign bus.d_rdata   = bus.d_data_ok ? rsp_data : 64'h0;

  assign bus.busy    = busy;
  assign bus.timeout = timeout_q;

endmodule
